keypad_scanner: RTL and testbench



---
 rtl/clock_pkg.sv | 25 ++
 rtl/keypad_scanner_if.sv | 13 +
 rtl/scan_tick_gen.sv | 20 ++
 rtl/keypad_scanner.sv | 186 ++++++++++++++++++
 tb/tb_keypad_scanner.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/clock_pkg.sv
// Shared types and constants for the clock's keypad/display scan logic.
package clock_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2,
        RELEASE  = 2'd3
    } kp_state_e;

    typedef logic [3:0] key_code_t;

    localparam int KP_ROWS = 4;
    localparam int KP_COLS = 4;
    localparam logic [3:0] ROW_IDLE = 4'b1110;

    // Index of the lowest bit that is 0; works for both active-low rows and columns.
    function automatic logic [1:0] lowIndex(input logic [3:0] v);
        if (!v[0])      return 2'd0;
        else if (!v[1]) return 2'd1;
        else if (!v[2]) return 2'd2;
        else            return 2'd3;
    endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Key event bus from the keypad scanner to the time/alarm setting logic.
import clock_pkg::*;

interface keypad_scanner_if;
    // KeyValid is a one-cycle strobe with no ready/back-pressure: the consumer
    // must take KeyCode in the cycle KeyValid is high; KeyCode holds between strobes.
    key_code_t KeyCode;
    logic      KeyValid;
    logic      KeyHeld;

    modport master (output KeyCode, output KeyValid, output KeyHeld);
    modport slave  (input  KeyCode, input  KeyValid, input  KeyHeld);
endinterface

// File: rtl/scan_tick_gen.sv
// Free-running prescaler giving a one-cycle tick every DIV clocks; shared with the display scanner.
module scan_tick_gen #(
    parameter int DIV = 10
) (
    input  logic CLK,
    input  logic Rstn,
    output logic tick
);
    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [W-1:0] preCnt;

    assign tick = (preCnt == W'(DIV - 1));

    always_ff @(posedge CLK) begin
        if (!Rstn)     preCnt <= '0;
        else if (tick) preCnt <= '0;
        else           preCnt <= preCnt + 1'b1;
    end
endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: row scan, column sync, debounce, one strobe per press.
// Optional auto-repeat while held is enabled by defining KEY_REPEAT_EN.
import clock_pkg::*;

module keypad_scanner #(
    parameter int CLK_FREQ_HZ    = 50000000,
    parameter int SCAN_HZ        = 1000,
    parameter int DEBOUNCE_SCANS = 20,
    parameter int REPEAT_DELAY   = 500,
    parameter int REPEAT_PERIOD  = 100
) (
    input  logic                 CLK,
    input  logic                 Rstn,
    input  logic [KP_COLS-1:0]   Col_In,
    output logic [KP_ROWS-1:0]   Row_Out,
    keypad_scanner_if.master     keyBus,
    output kp_state_e            DbgState
);
    localparam int DIV = CLK_FREQ_HZ / SCAN_HZ;
    localparam int CW  = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CW-1:0] DS  = CW'(DEBOUNCE_SCANS);
    localparam logic [CW-1:0] ONE = CW'(1);

    if (DIV < 2) begin : g_bad_div
        $error("keypad_scanner: CLK_FREQ_HZ/SCAN_HZ must be >= 2");
    end
    if (DEBOUNCE_SCANS < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_counts
        $error("keypad_scanner: debounce/repeat counts must be >= 1");
    end

    logic tick;
    scan_tick_gen #(.DIV(DIV)) u_tick (.CLK(CLK), .Rstn(Rstn), .tick(tick));

    logic [KP_COLS-1:0] sync1, sync2;
    kp_state_e          state, stateN;
    logic [KP_ROWS-1:0] rowQ, rowN;
    logic [CW-1:0]      cnt, cntN;
    key_code_t          cand, candN, code, codeN;
    logic               valid, validN, held, heldN;
    logic               accept, releaseDone;
    logic               anyLow;
    key_code_t          sampCode;
    logic [KP_ROWS-1:0] rowNext;

`ifdef KEY_REPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);
    logic [RW-1:0] repCnt, repCntN;
    logic          repFirstDone, repFirstDoneN;
`endif

    assign anyLow   = (sync2 != '1);
    assign sampCode = {lowIndex(rowQ), lowIndex(sync2)};
    assign rowNext  = {rowQ[KP_ROWS-2:0], rowQ[KP_ROWS-1]};

    always_comb begin
        stateN      = state;
        rowN        = rowQ;
        cntN        = cnt;
        candN       = cand;
        codeN       = code;
        validN      = 1'b0;
        heldN       = held;
        accept      = 1'b0;
        releaseDone = 1'b0;
`ifdef KEY_REPEAT_EN
        repCntN       = repCnt;
        repFirstDoneN = repFirstDone;
`endif
        if (tick) begin
            case (state)
                SCAN: begin
                    if (!anyLow) begin
                        rowN = rowNext;
                    end else begin
                        candN  = sampCode;
                        cntN   = ONE;
                        stateN = DEBOUNCE;
                        accept = (ONE == DS);
                    end
                end
                DEBOUNCE: begin
                    // All-high drops back to SCAN on the same row, so the key is re-found next tick.
                    if (!anyLow) begin
                        stateN = SCAN;
                        cntN   = '0;
                    end else begin
                        if (sampCode == cand) begin
                            cntN = cnt + ONE;
                        end else begin
                            candN = sampCode;
                            cntN  = ONE;
                        end
                        accept = (cntN == DS);
                    end
                end
                PRESSED: begin
                    if (!anyLow) begin
                        cntN        = ONE;
                        stateN      = RELEASE;
                        releaseDone = (ONE == DS);
                    end else begin
`ifdef KEY_REPEAT_EN
                        repCntN = repCnt + 1'b1;
                        if (repCntN == (repFirstDone ? RW'(REPEAT_PERIOD) : RW'(REPEAT_DELAY))) begin
                            validN        = 1'b1;
                            repCntN       = '0;
                            repFirstDoneN = 1'b1;
                        end
`endif
                    end
                end
                RELEASE: begin
                    if (anyLow) begin
                        cntN   = '0;
                        stateN = PRESSED;
                    end else begin
                        cntN        = cnt + ONE;
                        releaseDone = (cntN == DS);
                    end
                end
                default: stateN = SCAN;
            endcase
        end

        if (accept) begin
            codeN  = candN;
            validN = 1'b1;
            heldN  = 1'b1;
            cntN   = '0;
            stateN = PRESSED;
`ifdef KEY_REPEAT_EN
            repCntN       = '0;
            repFirstDoneN = 1'b0;
`endif
        end
        if (releaseDone) begin
            heldN  = 1'b0;
            cntN   = '0;
            rowN   = rowNext;
            stateN = SCAN;
        end
    end

    always_ff @(posedge CLK) begin
        if (!Rstn) begin
            sync1 <= '1;
            sync2 <= '1;
            state <= SCAN;
            rowQ  <= ROW_IDLE;
            cnt   <= '0;
            cand  <= '0;
            code  <= '0;
            valid <= 1'b0;
            held  <= 1'b0;
        end else begin
            sync1 <= Col_In;
            sync2 <= sync1;
            state <= stateN;
            rowQ  <= rowN;
            cnt   <= cntN;
            cand  <= candN;
            code  <= codeN;
            valid <= validN;
            held  <= heldN;
        end
    end

`ifdef KEY_REPEAT_EN
    always_ff @(posedge CLK) begin
        if (!Rstn) begin
            repCnt       <= '0;
            repFirstDone <= 1'b0;
        end else begin
            repCnt       <= repCntN;
            repFirstDone <= repFirstDoneN;
        end
    end
`endif

    assign Row_Out         = rowQ;
    assign keyBus.KeyCode  = code;
    assign keyBus.KeyValid = valid;
    assign keyBus.KeyHeld  = held;
    assign DbgState        = state;
endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: a 16-key matrix model driven from the row outputs.
import clock_pkg::*;

module tb_keypad_scanner;
    logic       CLK = 1'b0;
    logic       Rstn = 1'b0;
    logic [3:0] Col_In;
    logic [3:0] Row_Out;
    kp_state_e  DbgState;
    logic [15:0] pressed = '0;

    int checks = 0;
    int failures = 0;
    int validCount = 0;
    int tbPre = 0;

    keypad_scanner_if keyBus();

    keypad_scanner #(
        .CLK_FREQ_HZ(100), .SCAN_HZ(10), .DEBOUNCE_SCANS(3),
        .REPEAT_DELAY(5), .REPEAT_PERIOD(2)
    ) dut (
        .CLK(CLK), .Rstn(Rstn), .Col_In(Col_In), .Row_Out(Row_Out),
        .keyBus(keyBus), .DbgState(DbgState)
    );

    // clock / reset / timing reference
    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (!Rstn) tbPre <= 0;
        else       tbPre <= (tbPre == 9) ? 0 : tbPre + 1;
    end

    always @(negedge CLK) begin
        if (keyBus.KeyValid === 1'b1) validCount <= validCount + 1;
    end

    // key matrix: a pressed key pulls its column low while its row is driven low
    always_comb begin
        Col_In = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !Row_Out[r]) Col_In[c] = 1'b0;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    // driver tasks
    task automatic step_tick();
        while (tbPre != 9) begin
            @(posedge CLK); #1;
        end
        @(posedge CLK); #1;
    endtask

    task automatic step_ticks(input int n);
        for (int i = 0; i < n; i++) step_tick();
    endtask

    task automatic do_reset();
        Rstn = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        Rstn = 1'b1;
    endtask

    // tests
    task automatic test_reset();
        pressed = '0;
        do_reset();
        checks++; if (Row_Out !== 4'b1110) begin failures++; $display("FAIL reset_row got=%b exp=1110", Row_Out); end
        checks++; if (keyBus.KeyCode !== 4'd0) begin failures++; $display("FAIL reset_code got=%0d exp=0", keyBus.KeyCode); end
        checks++; if (keyBus.KeyValid !== 1'b0 || keyBus.KeyHeld !== 1'b0) begin failures++; $display("FAIL reset_flags got=%b%b exp=00", keyBus.KeyValid, keyBus.KeyHeld); end
        checks++; if (DbgState !== SCAN) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", int'(DbgState), int'(SCAN)); end
        step_tick();
        checks++; if (Row_Out !== 4'b1101) begin failures++; $display("FAIL scan_tick1 got=%b exp=1101", Row_Out); end
        step_tick();
        checks++; if (Row_Out !== 4'b1011) begin failures++; $display("FAIL scan_tick2 got=%b exp=1011", Row_Out); end
        step_tick();
        checks++; if (Row_Out !== 4'b0111) begin failures++; $display("FAIL scan_tick3 got=%b exp=0111", Row_Out); end
        step_tick();
        checks++; if (Row_Out !== 4'b1110) begin failures++; $display("FAIL scan_wrap got=%b exp=1110", Row_Out); end
        checks++; if (validCount !== 0) begin failures++; $display("FAIL scan_no_strobe got=%0d exp=0", validCount); end
    endtask

    task automatic test_clean_press();
        int v0;
        v0 = validCount;
        pressed[9] = 1'b1;
        step_ticks(4);
        checks++; if (validCount !== v0 || keyBus.KeyHeld !== 1'b0) begin failures++; $display("FAIL press_early got=%0d/%b exp=%0d/0", validCount, keyBus.KeyHeld, v0); end
        checks++; if (Row_Out !== 4'b1011) begin failures++; $display("FAIL press_row_frozen got=%b exp=1011", Row_Out); end
        step_tick();
        checks++; if (keyBus.KeyValid !== 1'b1) begin failures++; $display("FAIL press_strobe got=%b exp=1", keyBus.KeyValid); end
        checks++; if (keyBus.KeyCode !== 4'd9) begin failures++; $display("FAIL press_code got=%0d exp=9", keyBus.KeyCode); end
        checks++; if (keyBus.KeyHeld !== 1'b1 || DbgState !== PRESSED) begin failures++; $display("FAIL press_held got=%b/%0d exp=1/%0d", keyBus.KeyHeld, int'(DbgState), int'(PRESSED)); end
        @(posedge CLK); #1;
        checks++; if (keyBus.KeyValid !== 1'b0) begin failures++; $display("FAIL press_strobe_width got=%b exp=0", keyBus.KeyValid); end
        pressed = '0;
        step_ticks(2);
        checks++; if (keyBus.KeyHeld !== 1'b1) begin failures++; $display("FAIL release_early got=%b exp=1", keyBus.KeyHeld); end
        step_tick();
        checks++; if (keyBus.KeyHeld !== 1'b0 || DbgState !== SCAN) begin failures++; $display("FAIL release_done got=%b/%0d exp=0/%0d", keyBus.KeyHeld, int'(DbgState), int'(SCAN)); end
        checks++; if (Row_Out !== 4'b0111) begin failures++; $display("FAIL release_row got=%b exp=0111", Row_Out); end
        checks++; if (validCount !== v0 + 1) begin failures++; $display("FAIL press_count got=%0d exp=%0d", validCount, v0 + 1); end
    endtask

    task automatic test_bounce();
        int v0;
        v0 = validCount;
        pressed[9] = 1'b1;
        step_ticks(4);
        checks++; if (DbgState !== DEBOUNCE) begin failures++; $display("FAIL bounce_enter got=%0d exp=%0d", int'(DbgState), int'(DEBOUNCE)); end
        for (int i = 0; i < 4; i++) begin
            pressed[9] = (i % 2 == 1);
            step_tick();
        end
        step_tick();
        checks++; if (validCount !== v0 || keyBus.KeyValid !== 1'b0) begin failures++; $display("FAIL bounce_early got=%0d exp=%0d", validCount, v0); end
        checks++; if (Row_Out !== 4'b1011) begin failures++; $display("FAIL bounce_row got=%b exp=1011", Row_Out); end
        step_tick();
        checks++; if (keyBus.KeyValid !== 1'b1 || keyBus.KeyCode !== 4'd9) begin failures++; $display("FAIL bounce_strobe got=%b/%0d exp=1/9", keyBus.KeyValid, keyBus.KeyCode); end
        pressed = '0;
        step_ticks(3);
        checks++; if (validCount !== v0 + 1 || Row_Out !== 4'b0111) begin failures++; $display("FAIL bounce_count got=%0d/%b exp=%0d/0111", validCount, Row_Out, v0 + 1); end
    endtask

    task automatic test_two_keys();
        int v0;
        v0 = validCount;
        pressed[0] = 1'b1;
        pressed[2] = 1'b1;
        step_ticks(4);
        checks++; if (keyBus.KeyValid !== 1'b1 || keyBus.KeyCode !== 4'd0) begin failures++; $display("FAIL two_keys_code got=%b/%0d exp=1/0", keyBus.KeyValid, keyBus.KeyCode); end
        pressed[13] = 1'b1;
        step_ticks(3);
        checks++; if (validCount !== v0 + 1) begin failures++; $display("FAIL other_row_ignored got=%0d exp=%0d", validCount, v0 + 1); end
        checks++; if (keyBus.KeyCode !== 4'd0 || Row_Out !== 4'b1110 || keyBus.KeyHeld !== 1'b1) begin failures++; $display("FAIL other_row_hold got=%0d/%b/%b exp=0/1110/1", keyBus.KeyCode, Row_Out, keyBus.KeyHeld); end
    endtask

    task automatic test_release_bounce();
        int v0;
        v0 = validCount;
        pressed = '0;
        step_ticks(2);
        checks++; if (DbgState !== RELEASE) begin failures++; $display("FAIL rel_state got=%0d exp=%0d", int'(DbgState), int'(RELEASE)); end
        pressed[0] = 1'b1;
        step_tick();
        checks++; if (DbgState !== PRESSED || keyBus.KeyHeld !== 1'b1) begin failures++; $display("FAIL rel_bounce got=%0d/%b exp=%0d/1", int'(DbgState), keyBus.KeyHeld, int'(PRESSED)); end
        pressed = '0;
        step_ticks(2);
        checks++; if (keyBus.KeyHeld !== 1'b1) begin failures++; $display("FAIL rel_restart got=%b exp=1", keyBus.KeyHeld); end
        step_tick();
        checks++; if (keyBus.KeyHeld !== 1'b0 || Row_Out !== 4'b1101) begin failures++; $display("FAIL rel_done got=%b/%b exp=0/1101", keyBus.KeyHeld, Row_Out); end
        checks++; if (validCount !== v0) begin failures++; $display("FAIL rel_no_strobe got=%0d exp=%0d", validCount, v0); end
    endtask

    task automatic test_mid_reset();
        int v1;
        int extra;
        pressed[5] = 1'b1;
        step_ticks(3);
        checks++; if (keyBus.KeyValid !== 1'b1 || keyBus.KeyCode !== 4'd5) begin failures++; $display("FAIL pre_reset_strobe got=%b/%0d exp=1/5", keyBus.KeyValid, keyBus.KeyCode); end
        Rstn = 1'b0;
        @(posedge CLK); #1;
        checks++; if (Row_Out !== 4'b1110 || keyBus.KeyCode !== 4'd0) begin failures++; $display("FAIL mid_reset_out got=%b/%0d exp=1110/0", Row_Out, keyBus.KeyCode); end
        checks++; if (keyBus.KeyValid !== 1'b0 || keyBus.KeyHeld !== 1'b0 || DbgState !== SCAN) begin failures++; $display("FAIL mid_reset_flags got=%b%b/%0d exp=00/0", keyBus.KeyValid, keyBus.KeyHeld, int'(DbgState)); end
        @(posedge CLK); #1;
        Rstn = 1'b1;
        v1 = validCount;
        step_ticks(3);
        checks++; if (validCount !== v1 || keyBus.KeyHeld !== 1'b0) begin failures++; $display("FAIL post_reset_early got=%0d/%b exp=%0d/0", validCount, keyBus.KeyHeld, v1); end
        step_tick();
        checks++; if (keyBus.KeyValid !== 1'b1 || keyBus.KeyCode !== 4'd5) begin failures++; $display("FAIL post_reset_strobe got=%b/%0d exp=1/5", keyBus.KeyValid, keyBus.KeyCode); end
`ifdef KEY_REPEAT_EN
        extra = 4;
`else
        extra = 0;
`endif
        step_ticks(12);
        checks++; if (validCount !== v1 + 1 + extra) begin failures++; $display("FAIL hold_strobes got=%0d exp=%0d", validCount, v1 + 1 + extra); end
        pressed = '0;
        step_ticks(3);
        checks++; if (keyBus.KeyHeld !== 1'b0 || keyBus.KeyCode !== 4'd5) begin failures++; $display("FAIL final_release got=%b/%0d exp=0/5", keyBus.KeyHeld, keyBus.KeyCode); end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_two_keys();
        test_release_bounce();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
